sr_flag_sequencer: RTL and testbench

- Controller for a bank of NFLAG enable-gated SR latches that hold status/flag bits.
- Takes set/clear requests from NREQ requesters and arbitrates between them round-robin.
- Drives the enable/S/R inputs of exactly one latch per transaction for a fixed hold window, then checks the latch's Q readback and acknowledges the requester.
- Sits between control logic and the latch bank; it is the only writer of that bank.

---
 rtl/sr_flag_sequencer_pkg.sv | 23 ++
 rtl/sr_flag_sequencer_rr_arbiter.sv | 37 +++
 rtl/sr_flag_sequencer.sv | 132 +++++++++++++
 tb/tb_sr_flag_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sr_flag_sequencer_pkg.sv
// Shared types and constants for the SR flag sequencer.
// Operation codes, FSM encoding and a clog2 helper.
package sr_flag_sequencer_pkg;

  localparam logic OP_CLEAR = 1'b0;
  localparam logic OP_SET   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2
  } state_e;

  function automatic int sr_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sr_flag_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter.
// Grants the first request at or after the pointer, wrapping.
module sr_rr_arbiter
  import sr_flag_sequencer_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PW-1:0]   gnt_idx_o,
  output logic            valid_o
);

  int   j;
  logic found;

  // scan from the pointer; first hit wins
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    valid_o   = 1'b0;
    found     = 1'b0;
    j         = 0;
    for (int off = 0; off < NREQ; off++) begin
      j = (int'(ptr_i) + off) % NREQ;
      if (!found && req_i[j]) begin
        found     = 1'b1;
        valid_o   = 1'b1;
        gnt_o[j]  = 1'b1;
        gnt_idx_o = PW'(j);
      end
    end
  end

endmodule

// File: rtl/sr_flag_sequencer.sv
// Sequencer for a bank of enable-gated SR flag latches.
// Arbitrates set/clear requests, drives one latch, checks Q.
module sr_flag_sequencer
  import sr_flag_sequencer_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int NFLAG    = 8,
  parameter int IDXW     = 3,
  parameter int HOLD_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      op,
  input  logic [NREQ*IDXW-1:0] idx,
  output logic [NREQ-1:0]      ack,
  output logic                 err,
  output logic [NFLAG-1:0]     latch_en,
  output logic [NFLAG-1:0]     latch_s,
  output logic [NFLAG-1:0]     latch_r,
  input  logic [NFLAG-1:0]     flag_q,
  output logic                 busy
);

  localparam int PW = sr_clog2(NREQ);
  localparam int CW = sr_clog2(HOLD_CYC + 1);

  if (IDXW < sr_clog2(NFLAG)) begin : g_idxw_chk
    $error("IDXW too narrow to address NFLAG latches");
  end

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              op_q, op_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              bad_q, bad_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [NREQ-1:0]   arb_gnt;
  logic [PW-1:0]     arb_idx;
  logic              arb_valid;
  logic [IDXW-1:0]   cap_idx;
  logic [NFLAG-1:0]  sel;
  logic              rb;

  sr_rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx),
    .valid_o   (arb_valid)
  );

  assign cap_idx = idx[arb_idx*IDXW +: IDXW];

  // state and captured request registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      op_q    <= OP_CLEAR;
      idx_q   <= '0;
      bad_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      bad_q   <= bad_d;
      cnt_q   <= cnt_d;
    end
  end

  // next-state: grant and capture in IDLE, hold in DRIVE
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    op_d    = op_q;
    idx_d   = idx_q;
    bad_d   = bad_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          gnt_d = arb_gnt;
          op_d  = op[arb_idx];
          idx_d = cap_idx;
          cnt_d = '0;
          if (int'(arb_idx) == NREQ - 1) ptr_d = '0;
          else ptr_d = arb_idx + 1'b1;
          if (32'(cap_idx) >= NFLAG) begin
            bad_d   = 1'b1;
            state_d = ST_CHECK;
          end else begin
            bad_d   = 1'b0;
            state_d = ST_DRIVE;
          end
        end
      end
      ST_DRIVE: begin
        if (32'(cnt_q) == HOLD_CYC - 1) state_d = ST_CHECK;
        else cnt_d = cnt_q + 1'b1;
      end
      ST_CHECK: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Moore decode of latch drive, ack and readback check
  always_comb begin
    sel = '0;
    for (int i = 0; i < NFLAG; i++) begin
      sel[i] = (32'(idx_q) == i);
    end
    latch_en = (state_q == ST_DRIVE) ? sel : '0;
    latch_s  = latch_en & {NFLAG{op_q}};
    latch_r  = latch_en & {NFLAG{~op_q}};
    rb       = |(sel & flag_q);
    ack      = (state_q == ST_CHECK) ? gnt_q : '0;
    err      = (state_q == ST_CHECK) && (bad_q || (rb != op_q));
    busy     = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_sr_flag_sequencer.sv
// Directed bench for sr_flag_sequencer with an SR latch model.
// Expected acks are queued at drive time and popped on ack.
module tb_sr_flag_sequencer;
  import sr_flag_sequencer_pkg::*;

  localparam int NREQ = 4;
  localparam int NFLAG = 8;
  localparam int IDXW = 3;
  localparam int HOLD = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] req, op, ack;
  logic [11:0] idx;
  logic err, busy;
  logic [7:0] len, ls, lr, flag_q;
  logic [7:0] bank = 8'h00;
  logic [7:0] stuck0 = 8'h00;

  logic [3:0] req6, op6, ack6;
  logic [11:0] idx6;
  logic err6, busy6;
  logic [5:0] len6, ls6, lr6, flag6;

  typedef struct {
    int r;
    bit e;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int n_vec = 0;
  int n_err = 0;

  sr_flag_sequencer #(
    .NREQ(NREQ), .NFLAG(NFLAG), .IDXW(IDXW), .HOLD_CYC(HOLD)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .idx(idx),
    .ack(ack), .err(err), .latch_en(len), .latch_s(ls),
    .latch_r(lr), .flag_q(flag_q), .busy(busy)
  );

  sr_flag_sequencer #(
    .NREQ(NREQ), .NFLAG(6), .IDXW(IDXW), .HOLD_CYC(HOLD)
  ) dut6 (
    .clk(clk), .rst(rst), .req(req6), .op(op6), .idx(idx6),
    .ack(ack6), .err(err6), .latch_en(len6), .latch_s(ls6),
    .latch_r(lr6), .flag_q(flag6), .busy(busy6)
  );

  always #5 clk = ~clk;

  assign flag_q = bank & ~stuck0;
  assign flag6 = 6'h00;

  always @(posedge clk) bank <= (bank & ~(len & lr)) | (len & ls);

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("inv_en_1hot", 32'($countones(len) <= 1), 32'(1));
      check("inv_s_and_r", 32'(ls & lr), 32'(0));
      check("inv_ack_1hot", 32'($countones(ack) <= 1), 32'(1));
      check("inv_err_wo_ack", 32'(err & ~|ack), 32'(0));
      if (ack != 4'b0) begin
        if (sb.size() == 0) begin
          check("sb_unexp_ack", 32'(ack), 32'(0));
        end else begin
          mon_e = sb.pop_front();
          check("sb_ack", 32'(ack), 32'(1) << mon_e.r);
          check("sb_err", 32'(err), 32'(mon_e.e));
        end
      end
    end
  end

  task automatic txn(int r, bit o, int ix, bit eerr, string tag);
    logic [IDXW-1:0] ixs;
    ixs = ix[IDXW-1:0];
    req[r] = 1'b1;
    op[r] = o;
    idx[r*IDXW +: IDXW] = ixs;
    sb.push_back('{r: r, e: eerr});
    for (int c = 0; c < HOLD; c++) begin
      @(negedge clk);
      check({tag, "_en"}, 32'(len), 32'(1) << ix);
      check({tag, "_s"}, 32'(ls), o ? (32'(1) << ix) : 32'(0));
      check({tag, "_r"}, 32'(lr), o ? 32'(0) : (32'(1) << ix));
      check({tag, "_busy"}, 32'(busy), 32'(1));
    end
    @(negedge clk);
    check({tag, "_ack"}, 32'(ack), 32'(1) << r);
    check({tag, "_err"}, 32'(err), 32'(eerr));
    check({tag, "_en_off"}, 32'(len), 32'(0));
    req[r] = 1'b0;
    @(negedge clk);
    check({tag, "_ack_off"}, 32'(ack), 32'(0));
    check({tag, "_idle"}, 32'(busy), 32'(0));
  endtask

  task automatic wait_ack(string tag);
    int n;
    n = 0;
    while (ack == 4'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, 32'(n < 20), 32'(1));
  endtask

  int order[5] = '{0, 1, 2, 3, 0};

  initial begin
    req = '0; op = '0; idx = '0;
    req6 = '0; op6 = '0; idx6 = '0;
    #1 rst = 1'b1;
    #2;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_ack", 32'(ack), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    check("rst_en", 32'(len), 32'(0));
    check("rst_s", 32'(ls), 32'(0));
    check("rst_r", 32'(lr), 32'(0));
    check("rst6_busy", 32'(busy6), 32'(0));
    check("rst6_en", 32'(len6), 32'(0));
    @(negedge clk);
    rst = 1'b0;

    // single set, requester 0, flag 5
    txn(0, 1'b1, 5, 1'b0, "set5");
    check("set5_bank", 32'(bank[5]), 32'(1));

    // readback mismatch: flag 3 stuck low
    stuck0 = 8'h08;
    txn(1, 1'b1, 3, 1'b1, "mism");
    stuck0 = 8'h00;

    // bad index on the 6-flag instance
    req6[2] = 1'b1;
    op6[2] = 1'b1;
    idx6[8:6] = 3'd7;
    @(negedge clk);
    check("bad_ack", 32'(ack6), 32'h4);
    check("bad_err", 32'(err6), 32'(1));
    check("bad_en", 32'(len6), 32'(0));
    req6[2] = 1'b0;
    @(negedge clk);
    check("bad_ack_off", 32'(ack6), 32'(0));
    check("bad_idle", 32'(busy6), 32'(0));

    // round-robin fairness with all four held, clearing 0..3
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req = 4'b1111;
    op = 4'b0000;
    idx = {3'd3, 3'd2, 3'd1, 3'd0};
    foreach (order[k]) sb.push_back('{r: order[k], e: 1'b0});
    foreach (order[k]) begin
      wait_ack("rr");
      check("rr_order", 32'(ack), 32'(1) << order[k]);
      if (k == 4) req = 4'b0000;
      @(negedge clk);
      check("rr_ack_1cyc", 32'(ack), 32'(0));
    end
    @(negedge clk);
    check("rr_idle", 32'(busy), 32'(0));
    check("rr_bank", 32'(bank[3:0]), 32'(0));

    // reset during first DRIVE cycle of requester 2
    req[2] = 1'b1;
    op[2] = 1'b1;
    idx[8:6] = 3'd6;
    @(negedge clk);
    check("rmid_en", 32'(len), 32'h40);
    #2 rst = 1'b1;
    #1;
    check("rmid_en0", 32'(len), 32'(0));
    check("rmid_s0", 32'(ls), 32'(0));
    check("rmid_r0", 32'(lr), 32'(0));
    check("rmid_busy0", 32'(busy), 32'(0));
    check("rmid_ack0", 32'(ack), 32'(0));
    req = 4'b1010;
    op = 4'b1010;
    idx = {3'd7, 3'd0, 3'd4, 3'd0};
    @(negedge clk);
    rst = 1'b0;
    sb.push_back('{r: 1, e: 1'b0});
    sb.push_back('{r: 3, e: 1'b0});
    wait_ack("rmid1");
    check("rmid_first", 32'(ack), 32'h2);
    req[1] = 1'b0;
    @(negedge clk);
    wait_ack("rmid2");
    check("rmid_second", 32'(ack), 32'h8);
    req[3] = 1'b0;
    @(negedge clk);

    // request changes after grant are ignored
    req[2] = 1'b1;
    op[2] = 1'b1;
    idx[8:6] = 3'd2;
    sb.push_back('{r: 2, e: 1'b0});
    @(negedge clk);
    op[2] = 1'b0;
    idx[8:6] = 3'd4;
    check("chg_en1", 32'(len), 32'h04);
    check("chg_s1", 32'(ls), 32'h04);
    @(negedge clk);
    check("chg_en2", 32'(len), 32'h04);
    check("chg_s2", 32'(ls), 32'h04);
    @(negedge clk);
    check("chg_ack", 32'(ack), 32'h4);
    check("chg_err", 32'(err), 32'(0));
    req[2] = 1'b0;
    check("chg_bank2", 32'(bank[2]), 32'(1));
    check("chg_bank4", 32'(bank[4]), 32'(1));
    @(negedge clk);
    @(negedge clk);

    check("sb_empty", 32'(sb.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
